// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM state encoding
// and access-size decode.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_D  = 3'd3;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;
  localparam logic [2:0] F3_WU = 3'd6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } lsu_state_e;

  // Access size in bytes (1, 2, 4, 8) from funct3[1:0].
  function automatic logic [3:0] size_bytes(input logic [2:0] funct3);
    return 4'd1 << funct3[1:0];
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational data alignment: load sign/zero extension and sub-doubleword
// store merge into the existing memory doubleword.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] rdata_i,
  input  logic [XLEN-1:0] wdata_i,
  output logic [XLEN-1:0] load_o,
  output logic [XLEN-1:0] store_o
);

  int unsigned     nbits;
  logic [XLEN-1:0] mask;
  logic [XLEN-1:0] ext;
  logic            sign;

  always_comb begin
    nbits = 32'(size_bytes(funct3_i)) << 3;
    mask  = '1;
    if (nbits < XLEN) mask = (XLEN'(1) << nbits) - XLEN'(1);
    ext   = rdata_i & mask;
    // Top bit of the mask isolates the sign bit of the accessed field.
    sign  = |(rdata_i & (mask ^ (mask >> 1)));

    load_o = ext;
    if (funct3_i == F3_D)                load_o = rdata_i;
    else if (funct3_i == 3'd7)           load_o = '0;
    else if (!funct3_i[2] && sign)       load_o = ext | ~mask;

    store_o = (rdata_i & ~mask) | (wdata_i & mask);
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: one load/store at a time, read-modify-write for
// sub-doubleword stores, bounds and funct3 fault checking at accept.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 64,
  parameter int unsigned XLEN      = 64
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_write,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_fault,
  output logic [XLEN-1:0] Mem_Addr,
  output logic [XLEN-1:0] Write_Data,
  output logic            memWrite,
  output logic            memRead,
  input  logic [XLEN-1:0] Read_Data
);

  lsu_state_e      state_q, state_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [2:0]      funct3_q, funct3_d;
  logic            write_q, write_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic [XLEN-1:0] resp_rdata_q, resp_rdata_d;
  logic            resp_fault_q, resp_fault_d;

  logic [XLEN-1:0] align_rdata;
  logic [XLEN-1:0] load_ext;
  logic [XLEN-1:0] store_merge;
  logic            req_fault;

  // Loads extend straight from the memory bus so the result is registered
  // on the same edge that captures the raw doubleword.
  assign align_rdata = (state_q == READ) ? Read_Data : rdata_q;

  lsu_align #(.XLEN(XLEN)) u_align (
    .funct3_i (funct3_q),
    .rdata_i  (align_rdata),
    .wdata_i  (wdata_q),
    .load_o   (load_ext),
    .store_o  (store_merge)
  );

  assign req_fault = (req_addr > XLEN'(MEM_BYTES - 8))
                   || (req_write && req_funct3[2])
                   || (!req_write && req_funct3 == 3'd7);

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    funct3_d     = funct3_q;
    write_d      = write_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    resp_rdata_d = '0;
    resp_fault_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d   = req_addr;
          funct3_d = req_funct3;
          write_d  = req_write;
          wdata_d  = req_wdata;
          if (req_fault) begin
            state_d      = RESP;
            resp_fault_d = 1'b1;
          end else if (req_write && size_bytes(req_funct3) == 4'd8) begin
            state_d = WRITE;
          end else begin
            state_d = READ;
          end
        end
      end
      READ: begin
        rdata_d = Read_Data;
        if (write_q) begin
          state_d = WRITE;
        end else begin
          state_d      = RESP;
          resp_rdata_d = load_ext;
        end
      end
      WRITE:   state_d = RESP;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      funct3_q     <= '0;
      write_q      <= 1'b0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      resp_rdata_q <= '0;
      resp_fault_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      funct3_q     <= funct3_d;
      write_q      <= write_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      resp_rdata_q <= resp_rdata_d;
      resp_fault_q <= resp_fault_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = resp_rdata_q;
  assign resp_fault = resp_fault_q;
  assign Mem_Addr   = addr_q;
  assign Write_Data = store_merge;
  // Gated with reset so a reset edge can never commit a memory write.
  assign memRead    = (state_q == READ) && reset;
  assign memWrite   = (state_q == WRITE) && reset;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed cases plus random traffic against a
// byte-array reference memory and an arithmetic load/store model.
module tb_load_store_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [63:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_fault;
  logic [63:0] Mem_Addr;
  logic [63:0] Write_Data;
  logic        memWrite;
  logic        memRead;
  logic [63:0] Read_Data;

  load_store_unit #(.MEM_BYTES(64), .XLEN(64)) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_fault (resp_fault),
    .Mem_Addr   (Mem_Addr),
    .Write_Data (Write_Data),
    .memWrite   (memWrite),
    .memRead    (memRead),
    .Read_Data  (Read_Data)
  );

  always #5 clock = ~clock;

  logic [7:0] mem     [0:63];
  logic [7:0] ref_mem [0:63];

  always_comb begin
    Read_Data = '0;
    if (Mem_Addr <= 64'd56)
      for (int i = 0; i < 8; i++) Read_Data[8*i +: 8] = mem[int'(Mem_Addr) + i];
  end

  always @(posedge clock) begin
    if (memWrite && Mem_Addr <= 64'd56)
      for (int i = 0; i < 8; i++) mem[int'(Mem_Addr) + i] <= Write_Data[8*i +: 8];
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Protocol invariants sampled every cycle outside reset.
  logic prev_rv = 1'b0;
  always @(negedge clock) begin
    if (reset) begin
      if (prev_rv) check_val("rv_consecutive", 64'(resp_valid), 64'd0);
      if (memRead || memWrite || resp_valid) check_val("ready_busy", 64'(req_ready), 64'd0);
      if (!resp_valid) begin
        check_val("rdata_idle", resp_rdata, 64'd0);
        check_val("fault_idle", 64'(resp_fault), 64'd0);
      end
    end
    prev_rv = resp_valid;
  end

  // Issues one request from an idle negedge, checks the response against the
  // reference model and updates the reference memory.
  task automatic run_req(input logic w, input logic [2:0] f3, input logic [63:0] a,
                         input logic [63:0] d, output logic [63:0] got);
    int          n, lat, cyc, rd, wr, wcyc;
    logic        flt;
    logic [63:0] exp_rd, exp_wd, wdat;
    n   = 1 << f3[1:0];
    flt = (a > 64'd56) || (w && f3 > 3'd3) || (!w && f3 == 3'd7);
    exp_rd = '0;
    exp_wd = '0;
    if (!flt) begin
      for (int i = 0; i < 8; i++)
        exp_wd[8*i +: 8] = (i < n) ? d[8*i +: 8] : ref_mem[int'(a) + i];
      if (!w) begin
        for (int i = 0; i < n; i++) exp_rd = exp_rd | (64'(ref_mem[int'(a) + i]) << (8*i));
        if (f3 < 3'd3 && exp_rd[8*n-1])
          for (int i = n; i < 8; i++) exp_rd = exp_rd | (64'hFF << (8*i));
      end
    end
    lat = flt ? 1 : (!w ? 2 : (n == 8 ? 2 : 3));

    check_val("ready_idle", 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = d;
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    cyc = 1; rd = 0; wr = 0; wcyc = 0; wdat = '0;
    while (cyc < 8) begin
      if (memRead) rd++;
      if (memWrite) begin wr++; wcyc = cyc; wdat = Write_Data; end
      if (resp_valid) break;
      @(negedge clock);
      cyc++;
    end
    check_val("resp_seen", 64'(resp_valid), 64'd1);
    check_val("latency", 64'(cyc), 64'(lat));
    check_val("fault", 64'(resp_fault), 64'(flt));
    check_val("rdata", resp_rdata, exp_rd);
    check_val("reads", 64'(rd), 64'((!flt && (!w || n < 8)) ? 1 : 0));
    check_val("writes", 64'(wr), 64'((!flt && w) ? 1 : 0));
    if (w && !flt) begin
      check_val("write_cycle", 64'(wcyc), 64'(lat - 1));
      check_val("write_data", wdat, exp_wd);
      for (int i = 0; i < 8; i++) ref_mem[int'(a) + i] = exp_wd[8*i +: 8];
    end
    got = resp_rdata;
    @(negedge clock);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] got;
    logic [7:0]  v;
    logic [5:0]  rv_bits, rdy_bits;
    logic        w;
    logic [2:0]  f3;
    logic [63:0] a;

    for (int i = 0; i < 64; i++) begin
      if (i < 8) v = 8'h80 + 8'(i);
      else if (i >= 16 && i < 24) v = 8'hAA;
      else v = 8'($urandom);
      mem[i] <= v;
      ref_mem[i] = v;
    end

    repeat (3) @(negedge clock);
    check_val("rst_ready", 64'(req_ready), 64'd1);
    check_val("rst_valid", 64'(resp_valid), 64'd0);
    check_val("rst_rdata", resp_rdata, 64'd0);
    check_val("rst_mem_en", 64'({memRead, memWrite}), 64'd0);
    reset = 1'b1;
    @(negedge clock);

    run_req(1'b0, 3'd0, 64'd0, 64'd0, got);
    check_val("lb_0", got, 64'hFFFF_FFFF_FFFF_FF80);
    run_req(1'b0, 3'd4, 64'd0, 64'd0, got);
    check_val("lbu_0", got, 64'h80);

    run_req(1'b1, 3'd3, 64'd8, 64'h1122334455667788, got);
    run_req(1'b0, 3'd3, 64'd8, 64'd0, got);
    check_val("ld_8", got, 64'h1122334455667788);

    run_req(1'b1, 3'd1, 64'd16, 64'hBEEF, got);
    run_req(1'b0, 3'd2, 64'd16, 64'd0, got);
    check_val("lw_16", got, 64'hFFFF_FFFF_AAAA_BEEF);
    run_req(1'b0, 3'd6, 64'd16, 64'd0, got);
    check_val("lwu_16", got, 64'hAAAA_BEEF);

    run_req(1'b0, 3'd3, 64'd57, 64'd0, got);
    run_req(1'b1, 3'd4, 64'd0, 64'h55, got);
    run_req(1'b0, 3'd3, 64'hFFFF_FFFF_FFFF_FFFC, 64'd0, got);
    run_req(1'b0, 3'd7, 64'd0, 64'd0, got);
    run_req(1'b0, 3'd3, 64'd56, 64'd0, got);

    // Reset in the WRITE cycle of an SB drops it.
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'd0; req_addr = 64'd24;
    req_wdata = 64'(~ref_mem[24]);
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    check_val("rmw_read", 64'(memRead), 64'd1);
    @(negedge clock);
    check_val("rmw_write_pre", 64'(memWrite), 64'd1);
    reset = 1'b0;
    #1;
    check_val("rmw_write_gated", 64'(memWrite), 64'd0);
    @(negedge clock);
    check_val("rmw_no_resp", 64'(resp_valid), 64'd0);
    reset = 1'b1;
    @(negedge clock);
    check_val("rmw_ready", 64'(req_ready), 64'd1);
    check_val("rmw_no_resp2", 64'(resp_valid), 64'd0);
    check_val("rmw_mem_kept", 64'(mem[24]), 64'(ref_mem[24]));

    // Back-to-back loads with req_valid held high.
    req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'd3; req_addr = 64'd0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      rv_bits[k]  = resp_valid;
      rdy_bits[k] = req_ready;
    end
    req_valid = 1'b0;
    check_val("b2b_valid", 64'(rv_bits), 64'b010010);
    check_val("b2b_ready", 64'(rdy_bits), 64'b100100);
    repeat (3) @(negedge clock);

    for (int t = 0; t < 80; t++) begin
      w  = 1'($urandom);
      f3 = 3'($urandom);
      if ($urandom_range(0, 9) == 0) a = {$urandom, $urandom};
      else a = 64'($urandom_range(0, 63));
      run_req(w, f3, a, {$urandom, $urandom}, got);
    end

    for (int i = 0; i < 64; i++)
      check_val($sformatf("mem%0d", i), 64'(mem[i]), 64'(ref_mem[i]));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator side of the data-memory port. Accepts one load or store request from the core pipeline at a time and drives Mem_Addr, Write_Data, memWrite and memRead.
- Sign- or zero-extends load data by RV64 width (funct3).
- Implements sub-doubleword stores (SB/SH/SW) as read-modify-write, because the data memory always writes 8 bytes.
- Sits between the execute stage and Data_Memory.

Parameters:
- MEM_BYTES, 64, size of the data memory in bytes; bounds for the fault check.
- XLEN, 64, data and address width.

Ports:
- clock  in  1  rising-edge clock shared with data memory.
- reset  in  1  synchronous, active-low reset (0 = reset), sampled on rising edge of clock.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request (high only in IDLE).
- req_write  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV64 funct3: 0 B, 1 H, 2 W, 3 D, 4 BU, 5 HU, 6 WU.
- req_addr  in  XLEN  byte address.
- req_wdata  in  XLEN  store data, right-justified.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  XLEN  extended load data; 0 for stores and faults.
- resp_fault  out  1  qualifies resp_valid; access was rejected.
- Mem_Addr  out  XLEN  memory byte address.
- Write_Data  out  XLEN  memory write data.
- memWrite  out  1  memory write enable; memory writes at the rising edge.
- memRead  out  1  memory read enable; read data is combinational.
- Read_Data  in  XLEN  memory read data, little-endian 8 bytes at Mem_Addr.

Behaviour:
- States: IDLE, READ, WRITE, RESP. State, captured request and captured read data are registered.
- Reset (reset==0 at a clock edge):
  - state=IDLE; all captured regs=0; resp_valid=0, resp_rdata=0, resp_fault=0.
  - memWrite and memRead are combinationally ANDed with reset, so no memory write occurs on a reset edge, even mid-WRITE.
  - Any in-flight request is dropped with no response.
- IDLE:
  - req_ready=1. Accept on req_valid at the edge and capture addr, funct3, write, wdata.
  - Size n = 1, 2, 4, 8 bytes from funct3[1:0].
- Fault check at accept:
  - Fault if req_addr > MEM_BYTES-8 (memory always touches 8 bytes).
  - Fault if a store has funct3 > 3.
  - Fault if a load has funct3 == 7.
  - On fault: go to RESP with resp_fault=1; no memory access occurs.
- Next state from IDLE:
  - load -> READ.
  - SD -> WRITE.
  - SB/SH/SW -> READ, then WRITE.
- READ:
  - memRead=1, Mem_Addr=captured addr.
  - Read_Data is captured at the end of the cycle.
  - Then: load -> RESP; store -> WRITE.
- WRITE:
  - memWrite=1 for exactly one cycle, Mem_Addr=captured addr.
  - Write_Data = SD ? wdata : {rdata_cap[63:8n], wdata[8n-1:0]}.
  - Then -> RESP.
- RESP:
  - resp_valid=1 for one cycle; no back-pressure.
  - resp_rdata for loads: B/H/W = sign-extend rdata_cap[8n-1:0]; BU/HU/WU = zero-extend; D = raw.
  - resp_rdata and resp_fault are registered outputs valid in the RESP cycle only, and 0 otherwise.
  - Then -> IDLE.
- Idle outputs: outside READ/WRITE, memRead=memWrite=0, and Mem_Addr/Write_Data hold their last values; the memory ignores them.
- Latency, counted from the accept edge to the resp_valid cycle:
  - load: 2 cycles.
  - SD: 2 cycles.
  - SB/SH/SW: 3 cycles.
  - fault: 1 cycle.
- Throughput: one request per (latency+1) cycles. A new request is accepted in the IDLE cycle following RESP.
- Alignment: none required. Any in-bounds address is accepted and the byte window starts at addr.
- Arithmetic: the bounds compare uses full XLEN unsigned math, so there is no wrap-around.

Decomposition:
- Shared package lsu_pkg:
  - funct3 constants F3_B..F3_WU.
  - state encoding (IDLE=0, READ=1, WRITE=2, RESP=3).
  - size-decode function.
- Sub-module lsu_align (combinational): load extend plus store merge, given funct3, rdata and wdata. It is reused by a future cache front end.

Test Plan:
- Memory bytes 0..7 = 0x80..0x87, LB addr 0 -> resp_rdata=0xFFFF_FFFF_FFFF_FF80 two cycles after accept; LBU addr 0 -> 0x80.
- SD addr 8 data 0x1122334455667788, then LD addr 8 -> 0x1122334455667788; exactly one memWrite pulse, no memRead during the SD.
- Bytes 16..23 = 0xAA, SH addr 16 data 0xBEEF -> memWrite in the 2nd cycle after accept, Write_Data=0xAAAAAAAAAAAABEEF, resp at 3rd cycle; LW addr 16 -> 0xFFFFFFFFAAAABEEF; LWU -> 0xAAAABEEF.
- LD addr 57 (MEM_BYTES=64) -> resp_fault=1 one cycle after accept, memRead/memWrite never asserted; store funct3=4 -> fault.
- Assert reset=0 in the WRITE cycle of an SB -> memWrite=0 that cycle, target bytes unchanged, no resp_valid, req_ready=1 after release.
- Back-to-back req_valid held high -> req_ready low in READ/WRITE/RESP; second request accepted in the IDLE cycle after RESP; resp_valid never two consecutive cycles.
